// File: rtl/arith_pkg.sv
// Shared opcodes, FSM state encoding and defaults for arith_scheduler.
package arith_pkg;

    localparam int NREQ_DEFAULT = 4;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic is_div0(input op_t op, input logic [7:0] b);
        return (op == OP_DIV) && (b == 8'd0);
    endfunction

endpackage

// File: rtl/arith_scheduler_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    logic [IW-1:0] idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/arith_scheduler.sv
// Shares one multicycle arithmetic unit among NREQ requesters (round-robin).
// Optional ARITH_SCHED_DIV0_CHECK_EN: answer divide-by-zero locally with rsp_err.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for any request; grant latches winner
// ST_ISSUE | au_start pulse to the unit
// ST_WAIT  | waiting for au_done, result captured on done
// ST_RESP  | ack pulse to the winner, pointer advances
module arith_scheduler
    import arith_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [15:0]       rsp_result,
    output logic              rsp_err,
    output logic              busy,
    output logic              au_start,
    output logic [1:0]        au_op,
    output logic [7:0]        au_a,
    output logic [7:0]        au_b,
    input  logic              au_done,
    input  logic [15:0]       au_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    op_t          op_arr [NREQ];
    logic [7:0]   a_arr  [NREQ];
    logic [7:0]   b_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[2*g+1:2*g];
        assign a_arr[g]  = req_a[8*g+7:8*g];
        assign b_arr[g]  = req_b[8*g+7:8*g];
    end

    logic          pick_any;
    logic [IW-1:0] pick_idx;

    state_t        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic          au_start_q, au_start_d;
    op_t           au_op_q, au_op_d;
    logic [7:0]    au_a_q, au_a_d;
    logic [7:0]    au_b_q, au_b_d;
    logic [15:0]   rsp_result_q, rsp_result_d;
    logic          busy_q, busy_d;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
    logic          rsp_err_q, rsp_err_d;
`endif

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        ptr_d        = ptr_q;
        ack_d        = '0;
        au_start_d   = 1'b0;
        au_op_d      = au_op_q;
        au_a_d       = au_a_q;
        au_b_d       = au_b_q;
        rsp_result_d = rsp_result_q;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d      = pick_idx;
                    au_op_d    = op_arr[pick_idx];
                    au_a_d     = a_arr[pick_idx];
                    au_b_d     = b_arr[pick_idx];
                    state_d    = ST_ISSUE;
                    au_start_d = 1'b1;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
                    // Divide-by-zero never reaches the unit; answer straight away.
                    if (is_div0(op_arr[pick_idx], b_arr[pick_idx])) begin
                        state_d         = ST_RESP;
                        au_start_d      = 1'b0;
                        ack_d[pick_idx] = 1'b1;
                        rsp_result_d    = 16'hFFFF;
                        rsp_err_d       = 1'b1;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (au_done) begin
                    rsp_result_d = au_result;
                    ack_d[win_q] = 1'b1;
                    state_d      = ST_RESP;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
                    rsp_err_d    = 1'b0;
`endif
                end
            end
            ST_RESP: begin
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            ptr_q        <= '0;
            ack_q        <= '0;
            au_start_q   <= 1'b0;
            au_op_q      <= OP_ADD;
            au_a_q       <= '0;
            au_b_q       <= '0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            ptr_q        <= ptr_d;
            ack_q        <= ack_d;
            au_start_q   <= au_start_d;
            au_op_q      <= au_op_d;
            au_a_q       <= au_a_d;
            au_b_q       <= au_b_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign au_start   = au_start_q;
    assign au_op      = au_op_q;
    assign au_a       = au_a_q;
    assign au_b       = au_b_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_arith_scheduler.sv
// Scoreboard bench for arith_scheduler: directed requests, behavioural unit, ack monitor.
module tb_arith_scheduler;
    import arith_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_op = '0;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic [N-1:0]   ack;
    logic [15:0]    rsp_result;
    logic           rsp_err;
    logic           busy;
    logic           au_start;
    logic [1:0]     au_op;
    logic [7:0]     au_a;
    logic [7:0]     au_b;
    logic           au_done = 1'b0;
    logic [15:0]    au_result = '0;

    arith_scheduler #(.NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .ack        (ack),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .au_start   (au_start),
        .au_op      (au_op),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_done    (au_done),
        .au_result  (au_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int start_count = 0;
    int cyc = 0;
    int start_cyc = 0;
    int unit_lat = 1;
    int drop_all_at = -1;
    bit auto_drop = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ack"},        32'(ack), 32'd0);
        chk({tag, "_au_start"},   32'(au_start), 32'd0);
        chk({tag, "_au_op"},      32'(au_op), 32'd0);
        chk({tag, "_au_a"},       32'(au_a), 32'd0);
        chk({tag, "_au_b"},       32'(au_b), 32'd0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_rsp_err"},    32'(rsp_err), 32'd0);
        chk({tag, "_busy"},       32'(busy), 32'd0);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req[i]           = 1'b1;
    endtask

    task automatic push_exp(input int idx, input logic [15:0] res, input logic err);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.err = err;
        expq.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        chk({name, "_ack_count"}, 32'(ack_count), 32'(target));
    endtask

    task automatic wait_start(input string name, input int base, input int budget);
        int n = 0;
        while (start_count <= base && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        chk({name, "_start_seen"}, 32'(start_count > base), 32'd1);
    endtask

    // behavioural arithmetic unit: done arrives unit_lat cycles after it sees au_start
    initial begin
        logic [1:0] u_op;
        logic [7:0] u_a, u_b;
        forever begin
            @(negedge clk);
            if (au_start === 1'b1) begin
                u_op = au_op;
                u_a  = au_a;
                u_b  = au_b;
                repeat (unit_lat + 1) @(posedge clk);
                #1;
                case (u_op)
                    OP_ADD:  au_result = {8'd0, u_a} + {8'd0, u_b};
                    OP_SUB:  au_result = {8'd0, u_a} - {8'd0, u_b};
                    OP_MUL:  au_result = {8'd0, u_a} * {8'd0, u_b};
                    default: au_result = (u_b == 8'd0) ? 16'hDEAD : {8'd0, u_a / u_b};
                endcase
                au_done = 1'b1;
                @(posedge clk);
                #1 au_done = 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every ack
    initial begin
        forever begin
            @(negedge clk);
            if (au_start === 1'b1) begin
                start_count++;
                start_cyc = cyc;
            end
            if (ack !== '0) begin
                chk("ack_onehot", 32'($countones(ack)), 32'd1);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=%b expected none (t=%0t)", ack, $time);
                end else begin
                    mon_e = expq.pop_front();
                    chk("ack_idx",    32'(ack), 32'(1) << mon_e.idx);
                    chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
                    chk("rsp_err",    32'(rsp_err), 32'(mon_e.err));
                    if (!mon_e.err)
                        chk("ack_latency", 32'(cyc - start_cyc), 32'(unit_lat + 2));
                end
                ack_count++;
                if (auto_drop) begin
                    for (int i = 0; i < N; i++)
                        if (ack[i]) req[i] = 1'b0;
                end else if (ack_count == drop_all_at) begin
                    req = '0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0;

        // reset values
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b1;

        // single requester add, operands disturbed after latching
        unit_lat = 1;
        s0 = start_count;
        push_exp(0, 16'd25, 1'b0);
        set_req(0, OP_ADD, 8'd15, 8'd10);
        wait_start("t1", s0, 20);
        req_a[7:0] = 8'd99;
        req_b[7:0] = 8'd77;
        chk("t1_au_a_stable", 32'(au_a), 32'd15);
        chk("t1_au_b_stable", 32'(au_b), 32'd10);
        chk("t1_au_op", 32'(au_op), 32'(OP_ADD));
        chk("t1_busy", 32'(busy), 32'd1);
        wait_acks("t1", 1, 30);
        chk("t1_starts", 32'(start_count - s0), 32'd1);
        repeat (2) @(posedge clk);
        #1 chk("t1_idle_busy", 32'(busy), 32'd0);

        // two simultaneous requests, slower unit
        do_reset();
        unit_lat = 3;
        a0 = ack_count;
        push_exp(0, 16'd15, 1'b0);
        push_exp(2, 16'd12, 1'b0);
        set_req(0, OP_SUB, 8'd20, 8'd5);
        set_req(2, OP_MUL, 8'd4, 8'd3);
        wait_acks("t2", a0 + 2, 60);

        // four requests held continuously: order 0,1,2,3,0
        do_reset();
        unit_lat = 1;
        a0 = ack_count;
        auto_drop = 1'b0;
        drop_all_at = a0 + 5;
        push_exp(0, 16'd3, 1'b0);
        push_exp(1, 16'd5, 1'b0);
        push_exp(2, 16'd15, 1'b0);
        push_exp(3, 16'd10, 1'b0);
        push_exp(0, 16'd3, 1'b0);
        set_req(0, OP_ADD, 8'd1, 8'd2);
        set_req(1, OP_SUB, 8'd9, 8'd4);
        set_req(2, OP_MUL, 8'd3, 8'd5);
        set_req(3, OP_DIV, 8'd50, 8'd5);
        wait_acks("t3", a0 + 5, 120);
        auto_drop = 1'b1;
        drop_all_at = -1;
        repeat (10) @(posedge clk);
        #1 chk("t3_no_extra", 32'(ack_count), 32'(a0 + 5));

        // reset while waiting on the unit, late au_done must be ignored
        do_reset();
        unit_lat = 8;
        a0 = ack_count;
        s0 = start_count;
        set_req(1, OP_ADD, 8'd1, 8'd1);
        wait_start("t4", s0, 20);
        repeat (2) @(posedge clk);
        #1 chk("t4_busy_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        req[1] = 1'b0;
        #1 check_idle_outputs("t4_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1 chk("t4_no_ack", 32'(ack_count), 32'(a0));
        chk("t4_busy_after", 32'(busy), 32'd0);
        unit_lat = 1;
        push_exp(2, 16'd300, 1'b0);
        set_req(2, OP_ADD, 8'd100, 8'd200);
        wait_acks("t4_next", a0 + 1, 30);

        // divide by zero, then a normal divide
        unit_lat = 2;
        a0 = ack_count;
        s0 = start_count;
`ifdef ARITH_SCHED_DIV0_CHECK_EN
        push_exp(3, 16'hFFFF, 1'b1);
`else
        push_exp(3, 16'hDEAD, 1'b0);
`endif
        set_req(3, OP_DIV, 8'd40, 8'd0);
        wait_acks("t5_div0", a0 + 1, 30);
`ifdef ARITH_SCHED_DIV0_CHECK_EN
        chk("t5_div0_starts", 32'(start_count - s0), 32'd0);
`else
        chk("t5_div0_starts", 32'(start_count - s0), 32'd1);
`endif
        push_exp(1, 16'd5, 1'b0);
        set_req(1, OP_DIV, 8'd40, 8'd8);
        wait_acks("t5_div", a0 + 2, 30);

        repeat (3) @(posedge clk);
        #1 chk("end_queue_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_scheduler.md
ARITH_SCHEDULER -- requirements
Module: arith_scheduler

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one multicycle arithmetic unit.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active low.
REQ-003 Requester-side ports SHALL be:
- req  input  NREQ  per-requester request, held until ack.
- req_op  input  2*NREQ  opcode of requester i at bits [2i+1:2i].
- req_a  input  8*NREQ  operand a of requester i at bits [8i+7:8i].
- req_b  input  8*NREQ  operand b of requester i at bits [8i+7:8i].
- ack  output  NREQ  one-cycle completion pulse to the served requester.
- rsp_result  output  16  result, valid only while any ack bit is high.
- rsp_err  output  1  error flag, valid with ack.
- busy  output  1  high in every state except IDLE.
REQ-004 Unit-side ports SHALL be:
- au_start  output  1  one-cycle start pulse.
- au_op  output  2  latched opcode (00 add, 01 sub, 10 mul, 11 div).
- au_a, au_b  output  8 each  latched operands.
- au_done  input  1  unit completion.
- au_result  input  16  unit result, sampled when au_done is high.

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-006 IDLE: if any req bit is high, the block SHALL pick winner by round-robin starting at pointer ptr, latch winner index, op, a, b, then go to ISSUE; else stay in IDLE.
REQ-007 ISSUE: au_start SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT.
REQ-008 WAIT: the FSM SHALL hold until au_done=1, capture au_result into rsp_result, then go to RESP; au_done SHALL be ignored in every other state.
REQ-009 RESP: ack[winner] SHALL be 1 for exactly one cycle, rsp_err=0, ptr=(winner+1) mod NREQ, then the FSM returns to IDLE.
REQ-010 au_op/au_a/au_b SHALL remain stable from ISSUE through WAIT; operand changes on req_* after latching SHALL have no effect.
REQ-011 Latency: ack SHALL assert exactly 3 cycles after the IDLE grant edge when au_done arrives 1 cycle after au_start; in general it asserts unit latency + 2 cycles after au_start.
REQ-012 A requester dropping req before grant SHALL be treated as withdrawn; dropping req after grant SHALL NOT abort; ack still pulses.
REQ-013 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester waits more than NREQ-1 transactions.
REQ-014 At most one ack bit SHALL be high in any cycle.

Reset
REQ-015 rst low SHALL immediately force state=IDLE, ptr=0, ack=0, au_start=0, au_op=0, au_a=0, au_b=0, rsp_result=0, rsp_err=0, busy=0.
REQ-016 Reset during ISSUE or WAIT SHALL abandon the transaction with no ack; a later au_done SHALL be ignored.

Configuration
REQ-017 Macro ARITH_SCHED_DIV0_CHECK_EN defined: a grant with op=11 and b=0 SHALL skip ISSUE/WAIT, go directly to RESP with rsp_result=16'hFFFF, rsp_err=1, no au_start.
REQ-018 Macro undefined: division by zero SHALL be issued to the unit normally and rsp_err SHALL be tied 0.

Structure
REQ-019 Shared package arith_pkg SHALL hold opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, FSM state encoding, and default NREQ.
REQ-020 Round-robin selection SHALL be a sub-module rr_pick (inputs req, ptr; outputs any, winner index).

Verification
REQ-021 Requester 0 only, add 15,10 -> one au_start; ack[0] pulse; rsp_result=25.
REQ-022 req[0] and req[2] same cycle, sub 20,5 and mul 4,3 -> ack[0] with 15, then ack[2] with 12.
REQ-023 All four req held continuously after reset -> ack order 0,1,2,3,0.
REQ-024 rst low during WAIT, au_done pulsed after release -> no ack; busy=0; next request served normally.
REQ-025 Div 40,0 with macro -> ack, rsp_err=1, rsp_result=FFFF, au_start never high; without macro -> au_start pulses; div 40,8 -> rsp_result=5.
